// File: rtl/wca_rd_arb.sv
// Weight-cache read arbiter: round-robin grant across PE-row requesters,
// merges requests that share the winner's address into one weight-buffer
// read, and fans the returned word out to every merged port.
module wca_rd_arb #(
    parameter int DATA_WIDTH     = 8,
    parameter int WEI_ADDR_WIDTH = 8,
    parameter int NUM_PORT       = 4
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    // PE-row request side
    input  logic [NUM_PORT-1:0]                      PERWCA_AdrVld,
    input  logic [NUM_PORT-1:0][WEI_ADDR_WIDTH-1:0]  PERWCA_Adr,
    output logic [NUM_PORT-1:0]                      WCAPER_AdrRdy,
    output logic [NUM_PORT-1:0]                      WCAPER_DatVld,
    output logic [NUM_PORT-1:0][DATA_WIDTH-1:0]      WCAPER_Dat,
    input  logic [NUM_PORT-1:0]                      PERWCA_DatRdy,
    // weight buffer side
    output logic                                     WCAWBF_AdrVld,
    output logic [WEI_ADDR_WIDTH-1:0]                WCAWBF_Adr,
    input  logic                                     WBFWCA_AdrRdy,
    input  logic                                     WBFWCA_DatVld,
    input  logic [DATA_WIDTH-1:0]                    WBFWCA_Dat,
    output logic                                     WCAWBF_DatRdy,
    // status
    output logic                                     ARB_Busy
);

    localparam int PTR_W = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]                state;
    logic [PTR_W-1:0]          rrPtr;
    logic [NUM_PORT-1:0]       pendMask;
    logic [WEI_ADDR_WIDTH-1:0] adrQ;
    logic [DATA_WIDTH-1:0]     datQ;

    logic                      anyVld;
    logic [PTR_W-1:0]          winner;
    logic [PTR_W-1:0]          nextPtr;
    logic [NUM_PORT-1:0]       grantMask;
    logic [NUM_PORT-1:0]       pendNext;

    // Round-robin search: first valid port starting at rrPtr, wrapping.
    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default first, so no path
        // through the block leaves it unassigned and infers a latch.
        anyVld = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_PORT; k++) begin
            idx = (int'(rrPtr) + k) % NUM_PORT;
            if (!anyVld && PERWCA_AdrVld[idx]) begin
                anyVld = 1'b1;
                winner = PTR_W'(idx);
            end
        end
        nextPtr = PTR_W'((int'(winner) + 1) % NUM_PORT);
    end

    // Accept the winner plus every requester asking for the same address.
    always_comb begin
        grantMask = '0;
        for (int i = 0; i < NUM_PORT; i++) begin
            grantMask[i] = (state == IDLE) && anyVld && PERWCA_AdrVld[i]
                           && (PERWCA_Adr[i] == PERWCA_Adr[winner]);
        end
    end

    // Pending ports still waiting for data after this cycle's accepts.
    assign pendNext = pendMask & ~PERWCA_DatRdy;

    // Arbiter state machine with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state    <= IDLE;
            rrPtr    <= '0;
            pendMask <= '0;
            adrQ     <= '0;
            datQ     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyVld) begin
                        adrQ     <= PERWCA_Adr[winner];
                        pendMask <= grantMask;
                        rrPtr    <= nextPtr;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (WBFWCA_AdrRdy) state <= WAIT;
                end
                WAIT: begin
                    if (WBFWCA_DatVld) begin
                        datQ  <= WBFWCA_Dat;
                        state <= RESP;
                    end
                end
                RESP: begin
                    pendMask <= pendNext;
                    if (pendNext == '0) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign WCAPER_AdrRdy = grantMask;
    assign WCAPER_DatVld = (state == RESP) ? pendMask : '0;
    assign WCAPER_Dat    = {NUM_PORT{datQ}};
    assign WCAWBF_AdrVld = (state == ISSUE);
    assign WCAWBF_Adr    = adrQ;
    assign WCAWBF_DatRdy = (state == WAIT);
    assign ARB_Busy      = (state != IDLE);

endmodule

// File: tb/tb_wca_rd_arb.sv
// Directed bench for wca_rd_arb: single read, round-robin order, address
// merge, back-pressure on both sides, and reset mid-transaction.
module tb_wca_rd_arb;

    logic            clk;
    logic            rst_n;
    logic [3:0]      perAdrVld;
    logic [3:0][7:0] perAdr;
    logic [3:0]      perAdrRdy;
    logic [3:0]      perDatVld;
    logic [3:0][7:0] perDat;
    logic [3:0]      perDatRdy;
    logic            wbfAdrVld;
    logic [7:0]      wbfAdr;
    logic            wbfAdrRdy;
    logic            wbfDatVld;
    logic [7:0]      wbfDat;
    logic            wbfDatRdy;
    logic            busy;

    int tests;
    int fails;

    wca_rd_arb #(.DATA_WIDTH(8), .WEI_ADDR_WIDTH(8), .NUM_PORT(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .PERWCA_AdrVld (perAdrVld),
        .PERWCA_Adr    (perAdr),
        .WCAPER_AdrRdy (perAdrRdy),
        .WCAPER_DatVld (perDatVld),
        .WCAPER_Dat    (perDat),
        .PERWCA_DatRdy (perDatRdy),
        .WCAWBF_AdrVld (wbfAdrVld),
        .WCAWBF_Adr    (wbfAdr),
        .WBFWCA_AdrRdy (wbfAdrRdy),
        .WBFWCA_DatVld (wbfDatVld),
        .WBFWCA_Dat    (wbfDat),
        .WCAWBF_DatRdy (wbfDatRdy),
        .ARB_Busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic checkIdleOutputs(input string tag);
        check({tag, " DatVld"}, 32'(perDatVld), 32'h0);
        check({tag, " WbfAdrVld"}, 32'(wbfAdrVld), 32'h0);
        check({tag, " WbfAdr"}, 32'(wbfAdr), 32'h0);
        check({tag, " WbfDatRdy"}, 32'(wbfDatRdy), 32'h0);
        check({tag, " Busy"}, 32'(busy), 32'h0);
        check({tag, " Dat"}, 32'(perDat), 32'h0);
        check({tag, " rrPtr"}, 32'(dut.rrPtr), 32'h0);
    endtask

    initial begin
        logic [1:0] order [5];
        tests = 0;
        fails = 0;
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        rst_n     = 1'b0;
        perAdrVld = '0;
        perAdr    = '0;
        perDatRdy = '0;
        wbfAdrRdy = 1'b0;
        wbfDatVld = 1'b0;
        wbfDat    = '0;
        tick();
        tick();
        checkIdleOutputs("reset");

        // ---- single request from port 2 ----
        rst_n     = 1'b1;
        perDatRdy = 4'hF;
        wbfAdrRdy = 1'b1;
        wbfDatVld = 1'b1;
        wbfDat    = 8'hA7;
        perAdrVld = 4'b0100;
        perAdr[2] = 8'h15;
        #1;
        check("single AdrRdy", 32'(perAdrRdy), 32'h4);
        tick();
        perAdrVld = '0;
        check("single WbfAdrVld", 32'(wbfAdrVld), 32'h1);
        check("single WbfAdr", 32'(wbfAdr), 32'h15);
        check("single rrPtr", 32'(dut.rrPtr), 32'h3);
        check("single Busy", 32'(busy), 32'h1);
        tick();
        check("single WbfAdrVld drop", 32'(wbfAdrVld), 32'h0);
        check("single WbfDatRdy", 32'(wbfDatRdy), 32'h1);
        tick();
        check("single DatVld", 32'(perDatVld), 32'h4);
        check("single Dat", 32'(perDat[2]), 32'hA7);
        tick();
        check("single DatVld clear", 32'(perDatVld), 32'h0);
        check("single Busy clear", 32'(busy), 32'h0);

        // ---- all four ports, distinct addresses, from rrPtr=0 ----
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        perAdrVld = 4'hF;
        perAdr    = {8'h13, 8'h12, 8'h11, 8'h10};
        #1;
        for (int g = 0; g < 5; g++) begin
            check($sformatf("rr%0d AdrRdy", g), 32'(perAdrRdy), 32'(4'b1 << order[g]));
            tick();
            check($sformatf("rr%0d WbfAdr", g), 32'(wbfAdr), 32'h10 + 32'(order[g]));
            check($sformatf("rr%0d AdrRdy busy", g), 32'(perAdrRdy), 32'h0);
            wbfDat = 8'hC0 + 8'(order[g]);
            tick();
            tick();
            check($sformatf("rr%0d DatVld", g), 32'(perDatVld), 32'(4'b1 << order[g]));
            check($sformatf("rr%0d Dat", g), 32'(perDat[order[g]]), 32'hC0 + 32'(order[g]));
            tick();
            check($sformatf("rr%0d idle", g), 32'(busy), 32'h0);
        end

        // ---- merge: ports 0 and 3 share 0x40, port 1 wants 0x41 ----
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        perAdrVld = 4'b1011;
        perAdr    = {8'h40, 8'h00, 8'h41, 8'h40};
        #1;
        check("merge AdrRdy", 32'(perAdrRdy), 32'h9);
        tick();
        perAdrVld = 4'b0010;
        wbfDat    = 8'h5A;
        check("merge WbfAdr", 32'(wbfAdr), 32'h40);
        tick();
        tick();
        check("merge DatVld", 32'(perDatVld), 32'h9);
        check("merge Dat0", 32'(perDat[0]), 32'h5A);
        check("merge Dat3", 32'(perDat[3]), 32'h5A);
        tick();
        check("merge rrPtr", 32'(dut.rrPtr), 32'h1);
        check("merge next AdrRdy", 32'(perAdrRdy), 32'h2);
        tick();
        perAdrVld = '0;
        wbfDat    = 8'h6B;
        check("merge next WbfAdr", 32'(wbfAdr), 32'h41);
        tick();
        tick();
        check("merge next DatVld", 32'(perDatVld), 32'h2);
        check("merge next Dat1", 32'(perDat[1]), 32'h6B);
        tick();
        check("merge next idle", 32'(busy), 32'h0);

        // ---- stalls: WBF address stall 5 cycles, port 1 slow 3 cycles ----
        wbfAdrRdy = 1'b0;
        perAdrVld = 4'b0011;
        perAdr    = {8'h00, 8'h00, 8'h22, 8'h22};
        #1;
        check("stall AdrRdy", 32'(perAdrRdy), 32'h3);
        tick();
        perAdrVld = '0;
        for (int s = 0; s < 5; s++) begin
            check($sformatf("stall%0d WbfAdrVld", s), 32'(wbfAdrVld), 32'h1);
            check($sformatf("stall%0d WbfAdr", s), 32'(wbfAdr), 32'h22);
            tick();
        end
        check("stall still issue", 32'(wbfAdrVld), 32'h1);
        wbfAdrRdy = 1'b1;
        perDatRdy = 4'b0001;
        wbfDat    = 8'h3C;
        tick();
        check("stall WbfDatRdy", 32'(wbfDatRdy), 32'h1);
        tick();
        check("stall DatVld both", 32'(perDatVld), 32'h3);
        check("stall Dat1", 32'(perDat[1]), 32'h3C);
        tick();
        check("stall port0 done", 32'(perDatVld), 32'h2);
        check("stall busy mid", 32'(busy), 32'h1);
        tick();
        check("stall port1 held", 32'(perDatVld), 32'h2);
        perDatRdy = 4'b0011;
        tick();
        check("stall DatVld end", 32'(perDatVld), 32'h0);
        check("stall idle", 32'(busy), 32'h0);

        // ---- reset while waiting for data ----
        wbfDatVld = 1'b0;
        perDatRdy = 4'hF;
        perAdrVld = 4'b0001;
        perAdr[0] = 8'h77;
        tick();
        perAdrVld = '0;
        check("rstwait WbfAdr", 32'(wbfAdr), 32'h77);
        tick();
        check("rstwait WbfDatRdy", 32'(wbfDatRdy), 32'h1);
        rst_n = 1'b0;
        tick();
        checkIdleOutputs("rstwait");
        rst_n     = 1'b1;
        wbfDatVld = 1'b1;
        wbfDat    = 8'hEE;
        #1;
        check("rstwait late DatRdy", 32'(wbfDatRdy), 32'h0);
        tick();
        check("rstwait no DatVld a", 32'(perDatVld), 32'h0);
        tick();
        check("rstwait no DatVld b", 32'(perDatVld), 32'h0);
        check("rstwait Dat", 32'(perDat), 32'h0);
        check("rstwait Busy", 32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wca_rd_arb.md
WCA_RD_ARB -- requirements
Module: wca_rd_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 8: weight data width.
REQ-002 Parameter WEI_ADDR_WIDTH, default 8: weight buffer address width.
REQ-003 Parameter NUM_PORT, default 4: number of PE-row requesters.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 PERWCA_AdrVld  in  NUM_PORT  per-port read-request valid.
REQ-007 PERWCA_Adr  in  NUM_PORT x WEI_ADDR_WIDTH  per-port read address.
REQ-008 WCAPER_AdrRdy  out  NUM_PORT  per-port request accept.
REQ-009 WCAPER_DatVld  out  NUM_PORT  per-port read-data valid.
REQ-010 WCAPER_Dat  out  NUM_PORT x DATA_WIDTH  per-port read data.
REQ-011 PERWCA_DatRdy  in  NUM_PORT  per-port data accept.
REQ-012 WCAWBF_AdrVld  out  1  read-address valid to the weight buffer.
REQ-013 WCAWBF_Adr  out  WEI_ADDR_WIDTH  read address to the weight buffer.
REQ-014 WBFWCA_AdrRdy  in  1  weight buffer address accept.
REQ-015 WBFWCA_DatVld  in  1  weight buffer read-data valid.
REQ-016 WBFWCA_Dat  in  DATA_WIDTH  weight buffer read data.
REQ-017 WCAWBF_DatRdy  out  1  read-data accept to the weight buffer.
REQ-018 ARB_Busy  out  1  high whenever state is not IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP; one read to the weight buffer is outstanding at most.
REQ-020 Every transfer SHALL complete only in a cycle with both Vld and Rdy high.
REQ-021 Round-robin pointer rr_ptr (log2 NUM_PORT bits) SHALL select winner = first port with AdrVld=1 searching rr_ptr, rr_ptr+1, ... modulo NUM_PORT.
REQ-022 IDLE with any AdrVld: WCAPER_AdrRdy SHALL be driven combinationally high for the winner and for every other requesting port whose address equals the winner's (merge); it is low for all other ports.
REQ-023 On that grant edge: address latched into adr_q, merged port set latched into pend_mask, rr_ptr <= (winner+1) mod NUM_PORT, state -> ISSUE.
REQ-024 IDLE with no AdrVld: remain IDLE; rr_ptr unchanged.
REQ-025 ISSUE: WCAWBF_AdrVld=1, WCAWBF_Adr=adr_q held stable; on WBFWCA_AdrRdy -> WAIT; otherwise remain.
REQ-026 WAIT: WCAWBF_DatRdy=1; on WBFWCA_DatVld latch WBFWCA_Dat into dat_q, -> RESP.
REQ-027 WCAWBF_DatRdy SHALL be 0 outside WAIT; WBFWCA_DatVld outside WAIT SHALL be ignored.
REQ-028 RESP: WCAPER_DatVld[i]=pend_mask[i]; WCAPER_Dat[i]=dat_q for all i; bit i cleared on PERWCA_DatRdy[i].
REQ-029 RESP -> IDLE on the edge where the last pend_mask bit clears (several bits may clear on one edge); a slow port SHALL not block data to other pending ports.
REQ-030 WCAPER_AdrRdy SHALL be 0 in ISSUE, WAIT, RESP; requests arriving then wait for IDLE.
REQ-031 Minimum latency: grant at edge T0, address handshake T1, data captured T2, WCAPER_DatVld high during cycle after T2, IDLE again one cycle after the PE accepts.
REQ-032 Ports with a different address from the winner SHALL not be accepted in that grant; they are served in rr order on later grants (no starvation: every requester is granted within NUM_PORT grants).

Reset
REQ-033 With rst_n=0 at a rising edge: state=IDLE, rr_ptr=0, pend_mask=0, adr_q=0, dat_q=0.
REQ-034 Reset values: WCAPER_DatVld=0, WCAPER_Dat=0, WCAWBF_AdrVld=0, WCAWBF_Adr=0, WCAWBF_DatRdy=0, ARB_Busy=0; WCAPER_AdrRdy follows REQ-022 from IDLE once rst_n=1.
REQ-035 Reset asserted in any state SHALL abandon the outstanding read; a late WBFWCA_DatVld after reset SHALL be ignored (DatRdy=0 in IDLE).

Verification
REQ-036 Single request: port 2 Adr=0x15, AdrRdy/DatVld tied 1, WBF data 0xA7 -> WCAWBF_Adr=0x15 one cycle, WCAPER_DatVld[2]=1 with 0xA7, rr_ptr=3.
REQ-037 All four ports request distinct addresses 0x10..0x13 continuously from rr_ptr=0 -> grant order 0,1,2,3,0; each port receives its own data exactly once per grant.
REQ-038 Merge: ports 0 and 3 Adr=0x40, port 1 Adr=0x41 -> one WBF read of 0x40 serves ports 0 and 3; port 1 granted next with read 0x41.
REQ-039 Stalls: WBFWCA_AdrRdy low 5 cycles, PERWCA_DatRdy[1] low 3 cycles while [0] high -> Adr stable during stall; port 0 completes first; IDLE only after port 1 accepts.
REQ-040 Reset in WAIT, then WBFWCA_DatVld=1 after release -> all outputs at reset values, WCAWBF_DatRdy=0, no WCAPER_DatVld pulse.
